// File: rtl/sa_param_pkg.sv
`default_nettype none
// sa_param_pkg: shared state encoding, operand-select codes and width helper
// for the parametrised systolic multiply engine.
package sa_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WRITE  = 2'd2
  } state_t;

  localparam logic LD_A = 1'b0;
  localparam logic LD_B = 1'b1;

  // Worst-case dot product of N signed DW-bit pairs fits without overflow.
  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sa_pe.sv
`default_nettype none
// sa_pe: output-stationary processing element; forwards operands one hop per
// cycle and accumulates their signed product.
module sa_pe
  import sa_param_pkg::*;
#(
  parameter int DW   = 8,
  parameter int ACCW = acc_width(4, DW)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [DW-1:0]   a_in,
  input  logic signed [DW-1:0]   b_in,
  output logic signed [DW-1:0]   a_out,
  output logic signed [DW-1:0]   b_out,
  output logic signed [ACCW-1:0] acc
);

  logic signed [2*DW-1:0] prod;

  assign prod = a_in * b_in;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + ACCW'(prod);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sa_mem_param.sv
`default_nettype none
// sa_mem_param: N x N systolic matrix-multiply engine with operand RAMs,
// skewed operand injection and read-modify-write result memory.
module sa_mem_param
  import sa_param_pkg::*;
#(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter int ACCW = acc_width(N, DW),
  parameter int RAW  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init,
  input  logic                    acc_mode,
  input  logic [RAW-1:0]          base_address,
  input  logic                    ld_en,
  input  logic                    ld_sel,
  input  logic [$clog2(N*N)-1:0]  ld_addr,
  input  logic [DW-1:0]           ld_data,
  input  logic [RAW-1:0]          rd_addr,
  output logic [ACCW-1:0]         rd_data,
  output logic                    busy,
  output logic                    com
);

  localparam int LAW = $clog2(N*N);
  localparam int CW  = $clog2(N*N + 3*N);
  localparam logic [CW-1:0] STREAM_LAST = CW'(3*N - 3);
  localparam logic [CW-1:0] WRITE_LAST  = CW'(N*N);

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            acc_mode_q;
  logic [RAW-1:0]  base_q;
  logic            accept, stream_en, wb_en, done, feed;

  logic [DW-1:0]   a_mem [N*N];
  logic [DW-1:0]   b_mem [N*N];
  logic [ACCW-1:0] c_mem [2**RAW];

  logic signed [DW-1:0]   a_w [N][N+1];
  logic signed [DW-1:0]   b_w [N+1][N];
  logic signed [ACCW-1:0] pe_acc [N*N];

  logic [ACCW-1:0] old_q, wr_data;
  logic [RAW-1:0]  rmw_addr, wr_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (init) state_nx = ST_STREAM;
      ST_STREAM: if (cnt == STREAM_LAST) state_nx = ST_WRITE;
      ST_WRITE:  if (cnt == WRITE_LAST) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    accept    = 1'b0;
    stream_en = 1'b0;
    wb_en     = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE:   accept = init;
      ST_STREAM: begin busy = 1'b1; stream_en = 1'b1; end
      ST_WRITE:  begin
        busy  = 1'b1;
        wb_en = (cnt != WRITE_LAST);
        done  = (cnt == WRITE_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      com        <= 1'b0;
      acc_mode_q <= 1'b0;
      base_q     <= '0;
    end else if (accept) begin
      cnt        <= '0;
      com        <= 1'b0;
      acc_mode_q <= acc_mode;
      base_q     <= base_address;
    end else if (stream_en) begin
      cnt <= (cnt == STREAM_LAST) ? '0 : cnt + 1'b1;
    end else if (wb_en) begin
      cnt <= cnt + 1'b1;
    end else if (done) begin
      cnt <= '0;
      com <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en && !busy) begin
      if (ld_sel == LD_B) b_mem[ld_addr] <= ld_data;
      else                a_mem[ld_addr] <= ld_data;
    end
  end

  // Row/column i is fed from its RAM for the first N stream cycles, then
  // delayed by i registers so operands meet in the right PE at the right time.
  assign feed = stream_en && (cnt < CW'(N));

  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [LAW-1:0] a_idx, b_idx;
    logic [DW-1:0]  a_src, b_src;

    assign a_idx = LAW'(i * N) + LAW'(cnt);
    assign b_idx = LAW'(int'(cnt) * N + i);
    assign a_src = feed ? a_mem[a_idx] : '0;
    assign b_src = feed ? b_mem[b_idx] : '0;

    if (i == 0) begin : g_direct
      assign a_w[i][0] = a_src;
      assign b_w[0][i] = b_src;
    end else begin : g_delay
      logic [DW-1:0] a_dly [i];
      logic [DW-1:0] b_dly [i];

      always_ff @(posedge clk) begin
        if (!rst_n || accept) begin
          for (int s = 0; s < i; s++) begin
            a_dly[s] <= '0;
            b_dly[s] <= '0;
          end
        end else begin
          a_dly[0] <= a_src;
          b_dly[0] <= b_src;
          for (int s = 1; s < i; s++) begin
            a_dly[s] <= a_dly[s-1];
            b_dly[s] <= b_dly[s-1];
          end
        end
      end

      assign a_w[i][0] = a_dly[i-1];
      assign b_w[0][i] = b_dly[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      sa_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (stream_en),
        .a_in  (a_w[i][j]),
        .b_in  (b_w[i][j]),
        .a_out (a_w[i][j+1]),
        .b_out (b_w[i+1][j]),
        .acc   (pe_acc[i*N + j])
      );
    end
  end

  // The old value for write k is fetched one cycle ahead; the fetch for k=0
  // happens on the final stream cycle so writes start right after.
  assign rmw_addr = (state == ST_WRITE) ? base_q + RAW'(cnt) + RAW'(1) : base_q;
  assign wr_addr  = base_q + RAW'(cnt);
  assign wr_data  = pe_acc[LAW'(cnt)] + (acc_mode_q ? old_q : '0);

  always_ff @(posedge clk) begin
    if (wb_en && rst_n) c_mem[wr_addr] <= wr_data;
    old_q <= c_mem[rmw_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= c_mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_sa_mem_param.sv
`default_nettype none
// tb_sa_mem_param: randomized bench comparing result memory contents and
// run timing against a plain matrix-product model.
module tb_sa_mem_param;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int ACCW = 18;
  localparam int RAW  = 8;
  localparam int NN   = N * N;
  localparam int LAW  = $clog2(NN);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            init = 1'b0;
  logic            acc_mode = 1'b0;
  logic [RAW-1:0]  base_address = '0;
  logic            ld_en = 1'b0;
  logic            ld_sel = 1'b0;
  logic [LAW-1:0]  ld_addr = '0;
  logic [DW-1:0]   ld_data = '0;
  logic [RAW-1:0]  rd_addr = '0;
  logic [ACCW-1:0] rd_data;
  logic            busy, com;

  int checks = 0;
  int errors = 0;
  int ma [NN];
  int mb [NN];
  logic [ACCW-1:0] ref_c [NN];

  sa_mem_param #(.N(N), .DW(DW), .ACCW(ACCW), .RAW(RAW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init         (init),
    .acc_mode     (acc_mode),
    .base_address (base_address),
    .ld_en        (ld_en),
    .ld_sel       (ld_sel),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .busy         (busy),
    .com          (com)
  );

  always #5 clk = ~clk;

  function automatic void compute_ref();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += ma[i*N + k] * mb[k*N + j];
        ref_c[i*N + j] = ACCW'(s);
      end
    end
  endfunction

  task automatic rand_ops();
    for (int x = 0; x < NN; x++) begin
      ma[x] = int'($signed(DW'($urandom)));
      mb[x] = int'($signed(DW'($urandom)));
    end
  endtask

  task automatic load_word(input logic sel, input int addr, input int val);
    @(negedge clk);
    ld_en = 1'b1; ld_sel = sel; ld_addr = LAW'(addr); ld_data = DW'(val);
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic load_ops();
    for (int x = 0; x < NN; x++) begin
      load_word(1'b0, x, ma[x]);
      load_word(1'b1, x, mb[x]);
    end
  endtask

  task automatic kick(input logic [RAW-1:0] base, input logic am);
    @(negedge clk);
    init = 1'b1; base_address = base; acc_mode = am;
    @(posedge clk);
    #1 init = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accepting edge.
  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cyc++;
      if (com) break;
    end
  endtask

  task automatic read_c(input logic [RAW-1:0] addr, output logic [ACCW-1:0] val);
    @(negedge clk);
    rd_addr = addr;
    @(negedge clk);
    val = rd_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (com !== 1'b0) begin errors++; $display("FAIL reset_com got %0b want 0", com); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %0d want 0", rd_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    int cyc, bc;
    logic [ACCW-1:0] v;
    for (int x = 0; x < NN; x++) begin
      ma[x] = ((x / N) == (x % N)) ? 1 : 0;
      mb[x] = x;
    end
    compute_ref();
    load_ops();
    kick(8'd0, 1'b0);
    wait_done(cyc, bc);
    checks++; if (cyc !== 3*N + NN) begin errors++; $display("FAIL ident_com_cycle got %0d want %0d", cyc, 3*N + NN); end
    checks++; if (bc !== 3*N - 1 + NN) begin errors++; $display("FAIL ident_busy_len got %0d want %0d", bc, 3*N - 1 + NN); end
    for (int k = 0; k < NN; k++) begin
      read_c(RAW'(k), v);
      checks++; if (v !== ref_c[k]) begin errors++; $display("FAIL ident_c[%0d] got %0d want %0d", k, v, ref_c[k]); end
    end
  endtask

  task automatic test_extremes();
    int cyc, bc;
    logic [ACCW-1:0] v;
    for (int x = 0; x < NN; x++) begin ma[x] = -128; mb[x] = -128; end
    compute_ref();
    load_ops();
    kick(8'd32, 1'b0);
    wait_done(cyc, bc);
    for (int k = 0; k < NN; k++) begin
      read_c(RAW'(32 + k), v);
      checks++; if (v !== ref_c[k]) begin errors++; $display("FAIL extreme_c[%0d] got %0d want %0d", k, v, ref_c[k]); end
    end
  endtask

  task automatic test_accum_wrap();
    int cyc, bc;
    logic [ACCW-1:0] v, want;
    rand_ops();
    compute_ref();
    load_ops();
    kick(8'd250, 1'b0);
    wait_done(cyc, bc);
    kick(8'd250, 1'b1);
    wait_done(cyc, bc);
    checks++; if (cyc !== 3*N + NN) begin errors++; $display("FAIL accum_com_cycle got %0d want %0d", cyc, 3*N + NN); end
    for (int k = 0; k < NN; k++) begin
      want = ref_c[k] + ref_c[k];
      read_c(RAW'(250 + k), v);
      checks++; if (v !== want) begin errors++; $display("FAIL accum_c[%0d] got %0d want %0d", k, v, want); end
    end
  endtask

  task automatic test_busy_protect();
    int cyc, bc;
    logic [ACCW-1:0] v;
    rand_ops();
    ma[0] = 5;
    mb[0] = 7;
    compute_ref();
    load_ops();
    kick(8'd64, 1'b0);
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        init = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = 8'd99;
      end else if (cyc == 6) begin
        init = 1'b0; ld_en = 1'b0;
      end
      if (com) break;
    end
    checks++; if (cyc !== 3*N + NN) begin errors++; $display("FAIL protect_com_cycle got %0d want %0d", cyc, 3*N + NN); end
    for (int k = 0; k < NN; k++) begin
      read_c(RAW'(64 + k), v);
      checks++; if (v !== ref_c[k]) begin errors++; $display("FAIL protect_c[%0d] got %0d want %0d", k, v, ref_c[k]); end
    end
    kick(8'd96, 1'b0);
    wait_done(cyc, bc);
    for (int k = 0; k < NN; k++) begin
      read_c(RAW'(96 + k), v);
      checks++; if (v !== ref_c[k]) begin errors++; $display("FAIL protect_rerun_c[%0d] got %0d want %0d", k, v, ref_c[k]); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc, bc;
    logic [ACCW-1:0] v;
    rand_ops();
    load_ops();
    kick(8'd200, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b want 0", busy); end
    checks++; if (com !== 1'b0) begin errors++; $display("FAIL midreset_com got %0b want 0", com); end
    rst_n = 1'b1;
    rand_ops();
    compute_ref();
    load_ops();
    kick(8'd200, 1'b0);
    wait_done(cyc, bc);
    checks++; if (cyc !== 3*N + NN) begin errors++; $display("FAIL midreset_com_cycle got %0d want %0d", cyc, 3*N + NN); end
    for (int k = 0; k < NN; k++) begin
      read_c(RAW'(200 + k), v);
      checks++; if (v !== ref_c[k]) begin errors++; $display("FAIL midreset_c[%0d] got %0d want %0d", k, v, ref_c[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    logic [ACCW-1:0] v;
    rand_ops();
    compute_ref();
    load_ops();
    @(negedge clk);
    init = 1'b1; base_address = 8'd100; acc_mode = 1'b0;
    @(posedge clk);
    #1 base_address = 8'd140;
    wait_done(cyc, bc);
    checks++; if (cyc !== 3*N + NN) begin errors++; $display("FAIL b2b_first_com_cycle got %0d want %0d", cyc, 3*N + NN); end
    @(negedge clk);
    checks++; if (com !== 1'b0) begin errors++; $display("FAIL b2b_com_drop got %0b want 0", com); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got %0b want 1", busy); end
    init = 1'b0;
    wait_done(cyc, bc);
    checks++; if (cyc !== 3*N + NN - 1) begin errors++; $display("FAIL b2b_second_com_cycle got %0d want %0d", cyc, 3*N + NN - 1); end
    for (int k = 0; k < NN; k++) begin
      read_c(RAW'(100 + k), v);
      checks++; if (v !== ref_c[k]) begin errors++; $display("FAIL b2b_run1_c[%0d] got %0d want %0d", k, v, ref_c[k]); end
      read_c(RAW'(140 + k), v);
      checks++; if (v !== ref_c[k]) begin errors++; $display("FAIL b2b_run2_c[%0d] got %0d want %0d", k, v, ref_c[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_extremes();
    test_accum_wrap();
    test_busy_protect();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
`default_nettype wire
